// File: rtl/irq_enc_pkg.sv
// Shared constants, state encoding and helpers for the 16-source event encoder.
package irq_enc_pkg;

  localparam int N_SRC  = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [CODE_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pri_sel16.sv
// Combinational 16-way priority selector; search begins at 'start' when rr_en=1,
// otherwise at index 0.
module pri_sel16
  import irq_enc_pkg::*;
(
  input  logic [N_SRC-1:0]  cand,
  input  logic [CODE_W-1:0] start,
  input  logic              rr_en,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [CODE_W-1:0] base;
  logic [N_SRC-1:0]  rot;
  logic [CODE_W-1:0] low;

  assign base = rr_en ? start : '0;

  // Rotate right by base so the search origin lands on bit 0; sums wrap at 16.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_rot
      localparam logic [CODE_W-1:0] OFS = CODE_W'(gi);
      logic [CODE_W-1:0] src;
      assign src     = OFS + base;
      assign rot[gi] = cand[src];
    end
  endgenerate

  always_comb begin
    low = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) low = CODE_W'(i);
    end
  end

  assign idx = low + base;
  assign any = |cand;

endmodule

// File: rtl/irq_encoder16.sv
// Sequential 16-to-4 event encoder: captures event pulses into a pending register
// and presents one pending index at a time over a valid/ack handshake.
module irq_encoder16
  import irq_enc_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  req,
  input  logic [N_SRC-1:0]  mask,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ack,
  output logic [N_SRC-1:0]  pending,
  output logic              dropped
);

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  state_t            state_reg, state_next;
  logic [N_SRC-1:0]  pending_reg, pending_next;
  logic [N_SRC-1:0]  clr, cand;
  logic [CODE_W-1:0] code_reg, code_next;
  logic [CODE_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_any;
  logic              valid_reg, valid_next;
  logic              dropped_reg, dropped_next;
  logic              accept;

  assign accept = valid_reg & ack;
  assign clr    = accept ? onehot(code_reg) : '0;

  // A new request in the ack cycle re-sets the bit, so set wins over clear.
  assign pending_next = (pending_reg & ~clr) | req;
  assign dropped_next = |(req & pending_reg & ~clr);
  assign cand         = pending_reg & ~mask;

  pri_sel16 u_sel (
    .cand  (cand),
    .start (rr_ptr_reg),
    .rr_en (RR_EN),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel_any) state_next = PRESENT;
      PRESENT: if (ack)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Code is only loaded from IDLE, so it cannot move while valid is high.
  always_comb begin
    code_next   = code_reg;
    valid_next  = valid_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          code_next  = sel_idx;
          valid_next = 1'b1;
        end else begin
          valid_next = 1'b0;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_next = 1'b0;
          if (RR_EN) rr_ptr_next = code_reg + CODE_W'(1);
        end
      end
      default: valid_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      dropped_reg <= 1'b0;
      rr_ptr_reg  <= '0;
    end else begin
      pending_reg <= pending_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      dropped_reg <= dropped_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  assign code    = code_reg;
  assign valid   = valid_reg;
  assign pending = pending_reg;
  assign dropped = dropped_reg;

endmodule

// File: tb/tb_irq_encoder16.sv
// Directed bench for irq_encoder16: one fixed-priority and one round-robin instance
// share stimulus; each check prints one line.
module tb_irq_encoder16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] mask;
  logic        ack;

  logic [3:0]  code_f, code_r;
  logic        valid_f, valid_r;
  logic [15:0] pending_f, pending_r;
  logic        dropped_f, dropped_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  irq_encoder16 #(.ROUND_ROBIN(0)) u_fixed (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .code(code_f),
    .valid(valid_f), .ack(ack), .pending(pending_f), .dropped(dropped_f)
  );

  irq_encoder16 #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .code(code_r),
    .valid(valid_r), .ack(ack), .pending(pending_r), .dropped(dropped_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    req  = '0;
    mask = '0;
    ack  = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  logic [15:0] exp_p;
  logic [15:0] tog_req  [4];
  logic [15:0] tog_mask [4];
  int first_cyc, last_cyc;

  initial begin
    rst  = 1'b0;
    req  = '0;
    mask = '0;
    ack  = 1'b0;
    tog_req[0]  = 16'h0001; tog_mask[0] = 16'h0200;
    tog_req[1]  = 16'h0000; tog_mask[1] = 16'hFFFF;
    tog_req[2]  = 16'h8100; tog_mask[2] = 16'h0000;
    tog_req[3]  = 16'h0003; tog_mask[3] = 16'h0202;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_valid_f", 32'(valid_f), 32'd0);
    check("rst_pending_f", 32'(pending_f), 32'd0);
    check("rst_code_f", 32'(code_f), 32'd0);
    check("rst_dropped_f", 32'(dropped_f), 32'd0);
    check("rst_valid_r", 32'(valid_r), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Idle with no requests: no spurious valid
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("idle_valid_%0d", k), 32'(valid_f), 32'd0);
    end

    // Reset mid-handshake
    req = 16'h0008;
    tick();
    req = '0;
    tick();
    check("mid_valid", 32'(valid_f), 32'd1);
    check("mid_code", 32'(code_f), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async_valid", 32'(valid_f), 32'd0);
    check("async_pending", 32'(pending_f), 32'd0);
    check("async_code", 32'(code_f), 32'd0);
    check("async_dropped", 32'(dropped_f), 32'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_rst_valid_%0d", k), 32'(valid_f), 32'd0);
    end

    // Fixed priority burst
    do_reset();
    req = 16'hFFFF;
    tick();
    req = '0;
    ack = 1'b1;
    first_cyc = 0;
    last_cyc  = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0)  first_cyc = cyc;
      if (i == 15) last_cyc  = cyc;
      exp_p = 16'hFFFF << i;
      check($sformatf("burst_valid_%0d", i), 32'(valid_f), 32'd1);
      check($sformatf("burst_code_%0d", i), 32'(code_f), 32'(i));
      check($sformatf("burst_pend_%0d", i), 32'(pending_f), 32'(exp_p));
      tick();
      check($sformatf("burst_bubble_%0d", i), 32'(valid_f), 32'd0);
    end
    check("burst_pend_end", 32'(pending_f), 32'd0);
    check("burst_span", 32'(last_cyc - first_cyc + 1), 32'd31);
    ack = 1'b0;

    // Round-robin wrap
    do_reset();
    req = 16'h4000;
    tick();
    req = '0;
    tick();
    check("rr_first_valid", 32'(valid_r), 32'd1);
    check("rr_first_code", 32'(code_r), 32'd14);
    ack = 1'b1;
    tick();
    req = 16'h8001;
    tick();
    req = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_valid_%0d", k), 32'(valid_r), 32'd1);
      check($sformatf("rr_code_%0d", k), 32'((k % 2 == 0) ? 15 : 0), 32'(code_r) ^ 32'd0);
      req = 16'h8001;
      tick();
      check($sformatf("rr_bubble_%0d", k), 32'(valid_r), 32'd0);
      req = '0;
    end
    ack = 1'b0;

    // Set wins over clear
    do_reset();
    req = 16'h0020;
    tick();
    req = '0;
    tick();
    check("sw_code", 32'(code_f), 32'd5);
    ack = 1'b1;
    req = 16'h0020;
    tick();
    ack = 1'b0;
    req = '0;
    check("sw_pend5", 32'(pending_f[5]), 32'd1);
    check("sw_dropped", 32'(dropped_f), 32'd0);
    check("sw_bubble", 32'(valid_f), 32'd0);
    tick();
    check("sw_revalid", 32'(valid_f), 32'd1);
    check("sw_recode", 32'(code_f), 32'd5);
    check("sw_dropped2", 32'(dropped_f), 32'd0);

    // Drop and mask
    do_reset();
    mask = 16'h0004;
    req  = 16'h0004;
    tick();
    req  = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mask_valid_%0d", k), 32'(valid_f), 32'd0);
      check($sformatf("mask_pend_%0d", k), 32'(pending_f), 32'h0004);
    end
    req = 16'h0004;
    tick();
    req = '0;
    check("drop_pulse", 32'(dropped_f), 32'd1);
    tick();
    check("drop_clear", 32'(dropped_f), 32'd0);
    mask = '0;
    for (int w = 0; w < 2 && !valid_f; w++) tick();
    check("unmask_valid", 32'(valid_f), 32'd1);
    check("unmask_code", 32'(code_f), 32'd2);

    // Latency and stability
    do_reset();
    req = 16'h0200;
    tick();
    req = '0;
    check("lat_pend_n1", 32'(pending_f), 32'h0200);
    check("lat_valid_n1", 32'(valid_f), 32'd0);
    tick();
    check("lat_valid_n2", 32'(valid_f), 32'd1);
    check("lat_code_n2", 32'(code_f), 32'd9);
    for (int k = 0; k < 4; k++) begin
      req  = tog_req[k];
      mask = tog_mask[k];
      tick();
      check($sformatf("stab_code_%0d", k), 32'(code_f), 32'd9);
      check($sformatf("stab_valid_%0d", k), 32'(valid_f), 32'd1);
    end
    req  = '0;
    mask = '0;
    ack  = 1'b1;
    tick();
    ack  = 1'b0;
    check("stab_acked", 32'(valid_f), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
